cla_adder_pipe: RTL

Parametrised, pipelined carry-lookahead adder/subtractor built from 4-bit lookahead groups, the successor to the fixed 16-bit combinational CLA. Width and pipeline depth are configurable. Operands enter and results leave through valid/ready handshakes, so the block sits directly in datapath streams between producer and consumer stages. Sustains one operation per cycle when not back-pressured.

---
 rtl/cla_adder_pipe.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/cla_adder_pipe.sv
// cla_adder_pipe: pipelined carry-lookahead adder/subtractor with valid/ready
// handshakes on both sides. The WIDTH/4 lookahead groups are split evenly over
// STAGES register stages. Each stage resolves its own groups from the carry
// registered by the stage before it, and carries the operand and sum slices
// forward.
// Optional macro CLA_ADDER_FLAGS_EN adds registered zero (z) and negative (n)
// result flags.
module cla_adder_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
`ifdef CLA_ADDER_FLAGS_EN
    ,
    output logic             z,
    output logic             n
`endif
);

    localparam int unsigned NG  = WIDTH / 4;
    localparam int unsigned GPS = NG / STAGES;
    localparam int unsigned SW  = GPS * 4;
    localparam int unsigned NP  = (STAGES > 1) ? STAGES - 1 : 1;
    localparam int unsigned LS  = STAGES - 1;

    logic [STAGES-1:0] vld_q;
    logic [STAGES-1:0] rdy;
    logic [STAGES-1:0] ld;

    logic [WIDTH-1:0]  st_a   [STAGES];
    logic [WIDTH-1:0]  st_b   [STAGES];
    logic [WIDTH-1:0]  st_p   [STAGES];
    logic [STAGES-1:0] st_c;

    logic [WIDTH-1:0]  sum_nx [STAGES];
    logic [WIDTH-1:0]  sum_q  [STAGES];
    logic [STAGES-1:0] c_nx;
    logic [STAGES-1:0] c_q;
    logic [WIDTH-1:0]  a_q    [NP];
    logic [WIDTH-1:0]  b_q    [NP];

    logic              ovf_nx;
    logic              ovf_q;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        localparam int unsigned LO = k * SW;

        logic [WIDTH-1:0] sum_d;
        logic             c_d;

        // Stage k can load unless it and everything downstream is full and stalled.
        assign rdy[k] = out_ready || !(&vld_q[LS:k]);

        if (k == 0) begin : g_first
            assign st_a[k] = a;
            assign st_b[k] = sub ? ~b : b;
            assign st_c[k] = cin ^ sub;
            assign st_p[k] = '0;
            assign ld[k]   = rdy[k] && in_valid;
        end else begin : g_next
            assign st_a[k] = a_q[k-1];
            assign st_b[k] = b_q[k-1];
            assign st_c[k] = c_q[k-1];
            assign st_p[k] = sum_q[k-1];
            assign ld[k]   = rdy[k] && vld_q[k-1];
        end

        // Resolve this stage's groups: 4-bit lookahead inside a group, group G/P chained across the stage.
        always_comb begin
            logic [3:0] g;
            logic [3:0] p;
            logic [3:0] c;
            logic       cg;
            g     = '0;
            p     = '0;
            c     = '0;
            sum_d = st_p[k];
            cg    = st_c[k];
            for (int j = 0; j < int'(GPS); j++) begin
                g    = st_a[k][LO + 4*j +: 4] & st_b[k][LO + 4*j +: 4];
                p    = st_a[k][LO + 4*j +: 4] ^ st_b[k][LO + 4*j +: 4];
                c[0] = cg;
                c[1] = g[0] | (p[0] & cg);
                c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cg);
                c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cg);
                sum_d[LO + 4*j +: 4] = p ^ c;
                cg = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
                   | ((&p) & cg);
            end
            c_d = cg;
        end

        assign sum_nx[k] = sum_d;
        assign c_nx[k]   = c_d;

        if (k == LS) begin : g_last
            assign ovf_nx = (st_a[k][WIDTH-1] == st_b[k][WIDTH-1]) &&
                            (sum_d[WIDTH-1] != st_a[k][WIDTH-1]);
        end
    end

    // Stage valid bits; an empty upstream stage moves a bubble forward.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
        end else begin
            if (rdy[0]) vld_q[0] <= in_valid;
            for (int k = 1; k < int'(STAGES); k++) begin
                if (rdy[k]) vld_q[k] <= vld_q[k-1];
            end
        end
    end

    // Stage data: partial sums, stage carries and unconsumed operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            c_q <= '0;
            for (int k = 0; k < int'(STAGES); k++) sum_q[k] <= '0;
            for (int k = 0; k < int'(NP); k++) begin
                a_q[k] <= '0;
                b_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < int'(STAGES); k++) begin
                if (ld[k]) begin
                    sum_q[k] <= sum_nx[k];
                    c_q[k]   <= c_nx[k];
                end
            end
            for (int k = 0; k < int'(LS); k++) begin
                if (ld[k]) begin
                    a_q[k] <= st_a[k];
                    b_q[k] <= st_b[k];
                end
            end
        end
    end

    // Result flags, registered with the final sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (ld[LS]) begin
            ovf_q <= ovf_nx;
        end
    end

`ifdef CLA_ADDER_FLAGS_EN
    logic z_q;
    logic n_q;

    // Zero/negative flags of the final sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            z_q <= 1'b0;
            n_q <= 1'b0;
        end else if (ld[LS]) begin
            z_q <= (sum_nx[LS] == '0);
            n_q <= sum_nx[LS][WIDTH-1];
        end
    end

    assign z = z_q;
    assign n = n_q;
`endif

    assign in_ready  = rdy[0];
    assign out_valid = vld_q[LS];
    assign s         = sum_q[LS];
    assign cout      = c_q[LS];
    assign ovf       = ovf_q;

endmodule
